dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
Memory-side responder for the pipeline memory stage's S_R_* read port and S_W_* write port. It owns a byte-addressable data SRAM and serves one outstanding read or write at a time with parameterised latency. It returns read data right-aligned to the addressed byte and commits writes of 1/2/4/8 bytes. It sits between the memory stage and the data store; the memory stage is the only initiator.

Parameters:
ADDR_WIDTH, 64, request address width
DATA_WIDTH, 64, data width (one doubleword)
DEPTH_WORDS, 4096, SRAM depth in doublewords
BASE_ADDR, 64'h0, byte address mapped to SRAM word 0
READ_LATENCY, 2, cycles from read accept to S_R_DATA_VALID (>=1)
WRITE_LATENCY, 2, cycles from write accept to S_W_COMPLETE (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
S_R_ADDR  in  ADDR_WIDTH  read byte address
S_R_ADDR_VALID  in  1  read request; held high by the initiator until data is returned
S_R_DATA  out  DATA_WIDTH  read data; addressed byte in [7:0]
S_R_DATA_VALID  out  1  one-cycle pulse, read data valid
S_W_VALID  in  1  write request
S_W_ADDR  in  ADDR_WIDTH  write byte address
S_W_DATA  in  DATA_WIDTH  write data, right-aligned
S_W_SIZE  in  4  bytes = 2**S_W_SIZE[1:0]; [3:2] ignored
S_W_READY  out  1  responder can accept a write
S_W_COMPLETE  out  1  one-cycle pulse, write committed

Behaviour:
- Reset (reset==0 at posedge): state IDLE; S_R_DATA=0, S_R_DATA_VALID=0, S_W_COMPLETE=0. S_W_READY is forced 0 while reset is low. SRAM contents are not cleared. Any in-flight write is discarded and not committed. Any in-flight read produces no response.
- States: IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE. A down-counter is loaded with the latency on accept.
- S_W_READY = (state==IDLE) && !S_R_ADDR_VALID && reset. It is combinational.
- Read accept: in IDLE, S_R_ADDR_VALID=1.
  - Latch the address and go to RD_WAIT.
  - S_R_DATA_VALID pulses high exactly READ_LATENCY cycles after the accept edge, with S_R_DATA valid in the same cycle.
  - Then go to RD_DONE and stay there until S_R_ADDR_VALID is sampled 0, then return to IDLE.
  - S_R_DATA holds its last value between responses.
- Read data: word = mem[(addr-BASE_ADDR)>>3]; S_R_DATA = word >> (8*addr[2:0]). Bytes past the doubleword boundary read as 0. No sign extension is applied; the initiator extends.
- Write accept: S_W_VALID && S_W_READY. Latch addr, data and size, then go to WR_WAIT.
  - Commit bytes on the final WR_WAIT cycle. The byte enable is the size mask shifted by addr[2:0]; lanes beyond byte 7 are dropped.
  - S_W_COMPLETE pulses high WRITE_LATENCY cycles after the accept edge, in the commit cycle.
  - Then go to WR_DONE and stay there until S_W_VALID is sampled 0, then return to IDLE.
- Simultaneous read and write valid in IDLE: the read wins because S_W_READY is 0; the write waits.
- Out of range (addr<BASE_ADDR or addr-BASE_ADDR >= 8*DEPTH_WORDS): the read returns 0 and the write is dropped. Handshake timing is unchanged, including the COMPLETE pulse.
- A read returning in the same cycle as a commit to the same word cannot occur (single outstanding request).

Optional Feature:
DMEM_RESPONDER_ERR_EN.
- When defined, adds output port S_ERR (1 bit, reset 0). S_ERR pulses with S_R_DATA_VALID or S_W_COMPLETE when the access was out of range or crossed a doubleword boundary.
- When undefined, the port and its logic are absent and the data behaviour is identical.

Decomposition:
- Package dmem_pkg:
  - state enum
  - size codes BYTE=0, HALF=1, WORD=2, DOUBLE=3
  - function size_to_mask(size) returning an 8-bit byte mask
  - function in_range(addr)
- Sub-module dmem_sram_array: single-port synchronous RAM, DEPTH_WORDS x 64, 8-bit byte enables, 1-cycle read. The responder drives it and absorbs its cycle into READ_LATENCY.

Test Plan:
- Preload mem[0]=64'h8877665544332211, READ_LATENCY=2. Hold S_R_ADDR=0x3 valid → S_R_DATA_VALID at accept+2 with S_R_DATA=64'h0000008877665544, then RD_DONE until valid drops.
- Write addr 0x10, data 64'hAABB, size 1. Read 0x10 → 64'h000000000000AABB, COMPLETE at accept+2, neighbouring bytes unchanged.
- Write addr 0x1E, size 2, data 32'hDEADBEEF. Read 0x18 → bytes 6..7 = EF,BE, word 0x20 untouched; S_ERR=1 if ERR_EN.
- Raise read and write valid in the same cycle → read served first, S_W_READY=0 until RD_DONE exits, then the write is accepted.
- Assert reset low one cycle into WR_WAIT → no COMPLETE, memory unchanged, S_W_READY=0 during reset, 1 one cycle after release.
- Read addr BASE_ADDR+8*DEPTH_WORDS → S_R_DATA=0 at the normal latency; write to the same address → COMPLETE pulses, no SRAM change.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_DONE,
        WR_WAIT,
        WR_DONE
    } state_t;

    typedef enum logic [1:0] {
        BYTE   = 2'd0,
        HALF   = 2'd1,
        WORD   = 2'd2,
        DOUBLE = 2'd3
    } size_t;

    function automatic logic [7:0] size_to_mask(input logic [1:0] size);
        logic [7:0] mask;
        case (size)
            BYTE:    mask = 8'h01;
            HALF:    mask = 8'h03;
            WORD:    mask = 8'h0F;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // span is the mapped window size in bytes; the subtraction wraps for addr < base
    function automatic logic in_range(input logic [63:0] addr, input logic [63:0] base,
                                      input logic [63:0] span);
        logic [63:0] off;
        off = addr - base;
        return (addr >= base) && (off < span);
    endfunction

    function automatic logic [63:0] word_offset(input logic [63:0] addr, input logic [63:0] base);
        return (addr - base) >> 3;
    endfunction

    function automatic logic crosses_dword(input logic [2:0] lane, input logic [1:0] size);
        return ({1'b0, lane} + (4'd1 << size)) > 4'd8;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Read/write port bundle between the memory stage (master) and the responder (slave).
// S_ERR exists only when DMEM_RESPONDER_ERR_EN is defined.
interface dmem_responder_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] S_R_ADDR;
    logic                  S_R_ADDR_VALID;
    logic [DATA_WIDTH-1:0] S_R_DATA;
    logic                  S_R_DATA_VALID;
    logic                  S_W_VALID;
    logic [ADDR_WIDTH-1:0] S_W_ADDR;
    logic [DATA_WIDTH-1:0] S_W_DATA;
    logic [3:0]            S_W_SIZE;
    logic                  S_W_READY;
    logic                  S_W_COMPLETE;

`ifdef DMEM_RESPONDER_ERR_EN
    logic                  S_ERR;

    modport master (
        output S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA, S_W_SIZE,
        input  S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE, S_ERR
    );

    modport slave (
        input  S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA, S_W_SIZE,
        output S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE, S_ERR
    );
`else
    modport master (
        output S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA, S_W_SIZE,
        input  S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE
    );

    modport slave (
        input  S_R_ADDR, S_R_ADDR_VALID, S_W_VALID, S_W_ADDR, S_W_DATA, S_W_SIZE,
        output S_R_DATA, S_R_DATA_VALID, S_W_READY, S_W_COMPLETE
    );
`endif

endinterface

// File: rtl/dmem_sram_array.sv
// Single-port synchronous data RAM with byte enables and a one-cycle registered read.
module dmem_sram_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = 12,
    parameter int DATA_WIDTH  = 64
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic [IDX_W-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // rdata is only updated by reads, so it holds the last word between accesses
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < DATA_WIDTH/8; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder: one outstanding read or write, fixed latencies, byte-lane writes.
// Define DMEM_RESPONDER_ERR_EN to add the S_ERR out-of-range / boundary-crossing flag.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH    = 64,
    parameter int          DATA_WIDTH    = 64,
    parameter int          DEPTH_WORDS   = 4096,
    parameter logic [63:0] BASE_ADDR     = 64'h0,
    parameter int          READ_LATENCY  = 2,
    parameter int          WRITE_LATENCY = 2
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus
);

    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int          LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int          CNT_W   = $clog2(LAT_MAX + 1);
    localparam logic [63:0] SPAN    = 64'(DEPTH_WORDS) * 64'd8;
    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WRITE_LATENCY - 1);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            size_q;
    logic                  range_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  rd_valid_q;
    logic                  complete_q;

    logic                  rd_accept;
    logic                  commit;
    logic                  rd_in_range;
    logic                  wr_in_range;
    logic                  sram_en;
    logic [IDX_W-1:0]      sram_addr;
    logic [7:0]            sram_be;
    logic [DATA_WIDTH-1:0] sram_wdata;
    logic [DATA_WIDTH-1:0] sram_rdata;

    assign bus.S_W_READY      = (state == IDLE) && !bus.S_R_ADDR_VALID && reset;
    assign bus.S_R_DATA       = rd_data_q;
    assign bus.S_R_DATA_VALID = rd_valid_q;
    assign bus.S_W_COMPLETE   = complete_q;

    assign rd_in_range = in_range(64'(bus.S_R_ADDR), BASE_ADDR, SPAN);
    assign wr_in_range = in_range(64'(bus.S_W_ADDR), BASE_ADDR, SPAN);

    // The RAM read is launched on the accept edge so its cycle hides inside READ_LATENCY
    assign rd_accept  = (state == IDLE) && bus.S_R_ADDR_VALID && reset;
    assign commit     = (state == WR_WAIT) && (cnt == '0) && reset;
    assign sram_en    = (rd_accept && rd_in_range) || (commit && range_q);
    assign sram_addr  = commit ? IDX_W'(word_offset(64'(addr_q), BASE_ADDR))
                               : IDX_W'(word_offset(64'(bus.S_R_ADDR), BASE_ADDR));
    assign sram_be    = size_to_mask(size_q) << addr_q[2:0];
    assign sram_wdata = wdata_q << {addr_q[2:0], 3'b000};

    dmem_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W),
        .DATA_WIDTH  (DATA_WIDTH)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (commit),
        .be    (sram_be),
        .addr  (sram_addr),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

`ifdef DMEM_RESPONDER_ERR_EN
    logic err_q;
    logic cross_q;
    assign bus.S_ERR = err_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            complete_q <= 1'b0;
`ifdef DMEM_RESPONDER_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            rd_valid_q <= 1'b0;
            complete_q <= 1'b0;
`ifdef DMEM_RESPONDER_ERR_EN
            err_q      <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.S_R_ADDR_VALID) begin
                        addr_q  <= bus.S_R_ADDR;
                        range_q <= rd_in_range;
                        cnt     <= RD_CNT;
                        state   <= RD_WAIT;
`ifdef DMEM_RESPONDER_ERR_EN
                        cross_q <= 1'b0;
`endif
                    end else if (bus.S_W_VALID) begin
                        addr_q  <= bus.S_W_ADDR;
                        wdata_q <= bus.S_W_DATA;
                        size_q  <= bus.S_W_SIZE[1:0];
                        range_q <= wr_in_range;
                        cnt     <= WR_CNT;
                        state   <= WR_WAIT;
`ifdef DMEM_RESPONDER_ERR_EN
                        cross_q <= crosses_dword(bus.S_W_ADDR[2:0], bus.S_W_SIZE[1:0]);
`endif
                    end
                end
                RD_WAIT: begin
                    if (cnt == '0) begin
                        rd_data_q  <= range_q ? (sram_rdata >> {addr_q[2:0], 3'b000}) : '0;
                        rd_valid_q <= 1'b1;
                        state      <= RD_DONE;
`ifdef DMEM_RESPONDER_ERR_EN
                        err_q      <= !range_q;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_DONE: begin
                    if (!bus.S_R_ADDR_VALID) begin
                        state <= IDLE;
                    end
                end
                WR_WAIT: begin
                    if (cnt == '0) begin
                        complete_q <= 1'b1;
                        state      <= WR_DONE;
`ifdef DMEM_RESPONDER_ERR_EN
                        err_q      <= !range_q || cross_q;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WR_DONE: begin
                    if (!bus.S_W_VALID) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (16-word SRAM at base 0, latencies 2/2).
// Honours DMEM_RESPONDER_ERR_EN for the S_ERR checks.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    dmem_responder_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

    dmem_responder #(
        .ADDR_WIDTH    (64),
        .DATA_WIDTH    (64),
        .DEPTH_WORDS   (16),
        .BASE_ADDR     (64'h0),
        .READ_LATENCY  (2),
        .WRITE_LATENCY (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic err_now();
`ifdef DMEM_RESPONDER_ERR_EN
        return bus.S_ERR;
`else
        return 1'b0;
`endif
    endfunction

    // Issues a read from IDLE; lat counts cycles from the accept edge to the data-valid cycle
    task automatic do_read(input logic [63:0] a, output logic [63:0] d, output int lat,
                           output logic e, output logic valid_after);
        bus.S_R_ADDR       = a;
        bus.S_R_ADDR_VALID = 1'b1;
        lat = -1;
        d   = '0;
        e   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.S_R_DATA_VALID === 1'b1) begin
                lat = i - 1;
                d   = bus.S_R_DATA;
                e   = err_now();
                break;
            end
        end
        bus.S_R_ADDR_VALID = 1'b0;
        @(posedge clk); #1;
        valid_after = bus.S_R_DATA_VALID;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d, input logic [3:0] size,
                            output int lat, output logic e);
        bus.S_W_ADDR  = a;
        bus.S_W_DATA  = d;
        bus.S_W_SIZE  = size;
        bus.S_W_VALID = 1'b1;
        lat = -1;
        e   = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.S_W_COMPLETE === 1'b1) begin
                lat = i - 1;
                e   = err_now();
                break;
            end
        end
        bus.S_W_VALID = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset              = 1'b0;
        bus.S_R_ADDR       = '0;
        bus.S_R_ADDR_VALID = 1'b0;
        bus.S_W_VALID      = 1'b0;
        bus.S_W_ADDR       = '0;
        bus.S_W_DATA       = '0;
        bus.S_W_SIZE       = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.S_R_DATA_VALID !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_rvalid: got %b expected 0", bus.S_R_DATA_VALID);
        end
        checks++;
        if (bus.S_R_DATA !== 64'h0) begin
            errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", bus.S_R_DATA);
        end
        checks++;
        if (bus.S_W_COMPLETE !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_complete: got %b expected 0", bus.S_W_COMPLETE);
        end
        checks++;
        if (bus.S_W_READY !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_wready: got %b expected 0", bus.S_W_READY);
        end
`ifdef DMEM_RESPONDER_ERR_EN
        checks++;
        if (bus.S_ERR !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_err: got %b expected 0", bus.S_ERR);
        end
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.S_W_READY !== 1'b1) begin
            errors++; $display("[TB] FAIL idle_wready: got %b expected 1", bus.S_W_READY);
        end
    endtask

    task automatic test_preload();
        logic [63:0] addrs [4] = '{64'h00, 64'h10, 64'h18, 64'h20};
        logic [63:0] datas [4] = '{64'h8877665544332211, 64'h1122334455667788,
                                   64'h0, 64'h0123456789ABCDEF};
        int   lat;
        logic e;
        for (int i = 0; i < 4; i++) begin
            do_write(addrs[i], datas[i], 4'd3, lat, e);
            checks++;
            if (lat !== 2) begin
                errors++; $display("[TB] FAIL preload_lat[%0d]: got %0d expected 2", i, lat);
            end
        end
    endtask

    task automatic test_read_aligned();
        logic [63:0] d;
        int   lat;
        logic e, va;
        do_read(64'h3, d, lat, e, va);
        checks++;
        if (d !== 64'h0000008877665544) begin
            errors++; $display("[TB] FAIL read_0x3_data: got %h expected 0000008877665544", d);
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("[TB] FAIL read_0x3_lat: got %0d expected 2", lat);
        end
        checks++;
        if (va !== 1'b0) begin
            errors++; $display("[TB] FAIL read_pulse_width: got %b expected 0", va);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("[TB] FAIL read_0x3_err: got %b expected 0", e);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.S_R_DATA !== 64'h0000008877665544) begin
            errors++; $display("[TB] FAIL read_hold: got %h expected 0000008877665544", bus.S_R_DATA);
        end
    endtask

    task automatic test_half_write();
        logic [63:0] d;
        int   lat;
        logic e, va;
        do_write(64'h10, 64'hAABB, 4'd1, lat, e);
        checks++;
        if (lat !== 2) begin
            errors++; $display("[TB] FAIL half_lat: got %0d expected 2", lat);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++; $display("[TB] FAIL half_err: got %b expected 0", e);
        end
        do_read(64'h10, d, lat, e, va);
        checks++;
        if (d !== 64'h112233445566AABB) begin
            errors++; $display("[TB] FAIL half_read_0x10: got %h expected 112233445566AABB", d);
        end
        do_read(64'h11, d, lat, e, va);
        checks++;
        if (d !== 64'h00112233445566AA) begin
            errors++; $display("[TB] FAIL half_read_0x11: got %h expected 00112233445566AA", d);
        end
    endtask

    task automatic test_cross_write();
        logic [63:0] d;
        int   lat;
        logic e, va;
        // size field 4'h6: upper bits must be ignored, giving a 4-byte write
        do_write(64'h1E, 64'hDEADBEEF, 4'h6, lat, e);
        checks++;
        if (lat !== 2) begin
            errors++; $display("[TB] FAIL cross_lat: got %0d expected 2", lat);
        end
`ifdef DMEM_RESPONDER_ERR_EN
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("[TB] FAIL cross_err: got %b expected 1", e);
        end
`endif
        do_read(64'h18, d, lat, e, va);
        checks++;
        if (d !== 64'hBEEF000000000000) begin
            errors++; $display("[TB] FAIL cross_read_0x18: got %h expected BEEF000000000000", d);
        end
        do_read(64'h20, d, lat, e, va);
        checks++;
        if (d !== 64'h0123456789ABCDEF) begin
            errors++; $display("[TB] FAIL cross_next_word: got %h expected 0123456789ABCDEF", d);
        end
        do_read(64'h1F, d, lat, e, va);
        checks++;
        if (d !== 64'h00000000000000BE) begin
            errors++; $display("[TB] FAIL cross_read_0x1F: got %h expected 00000000000000BE", d);
        end
    endtask

    task automatic test_read_priority();
        logic [63:0] d;
        int   lat;
        logic e, va, ready_seen, got;
        bus.S_R_ADDR       = 64'h0;
        bus.S_R_ADDR_VALID = 1'b1;
        bus.S_W_ADDR       = 64'h28;
        bus.S_W_DATA       = 64'hCAFEF00D12345678;
        bus.S_W_SIZE       = 4'd3;
        bus.S_W_VALID      = 1'b1;
        #1;
        checks++;
        if (bus.S_W_READY !== 1'b0) begin
            errors++; $display("[TB] FAIL prio_wready_idle: got %b expected 0", bus.S_W_READY);
        end
        ready_seen = 1'b0;
        got        = 1'b0;
        d          = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            ready_seen |= (bus.S_W_READY !== 1'b0);
            if (bus.S_R_DATA_VALID === 1'b1) begin
                d   = bus.S_R_DATA;
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (got !== 1'b1 || d !== 64'h8877665544332211) begin
            errors++; $display("[TB] FAIL prio_read_data: got %h valid %b expected 8877665544332211", d, got);
        end
        @(posedge clk); #1;
        ready_seen |= (bus.S_W_READY !== 1'b0) || (bus.S_W_COMPLETE !== 1'b0);
        bus.S_R_ADDR_VALID = 1'b0;
        #1;
        ready_seen |= (bus.S_W_READY !== 1'b0);
        checks++;
        if (ready_seen !== 1'b0) begin
            errors++; $display("[TB] FAIL prio_wready_held: got %b expected 0", ready_seen);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.S_W_READY !== 1'b1) begin
            errors++; $display("[TB] FAIL prio_wready_release: got %b expected 1", bus.S_W_READY);
        end
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.S_W_COMPLETE === 1'b1) begin
                lat = i - 1;
                break;
            end
        end
        bus.S_W_VALID = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (lat !== 2) begin
            errors++; $display("[TB] FAIL prio_write_lat: got %0d expected 2", lat);
        end
        do_read(64'h28, d, lat, e, va);
        checks++;
        if (d !== 64'hCAFEF00D12345678) begin
            errors++; $display("[TB] FAIL prio_write_data: got %h expected CAFEF00D12345678", d);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [63:0] d;
        int   lat;
        logic e, va, comp_seen;
        bus.S_W_ADDR  = 64'h28;
        bus.S_W_DATA  = 64'h5555555555555555;
        bus.S_W_SIZE  = 4'd3;
        bus.S_W_VALID = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.S_W_VALID = 1'b0;
        #1;
        checks++;
        if (bus.S_W_READY !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_wready_low: got %b expected 0", bus.S_W_READY);
        end
        comp_seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            comp_seen |= (bus.S_W_COMPLETE !== 1'b0) || (bus.S_W_READY !== 1'b0);
        end
        checks++;
        if (comp_seen !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_no_complete: got %b expected 0", comp_seen);
        end
        checks++;
        if (bus.S_R_DATA !== 64'h0) begin
            errors++; $display("[TB] FAIL rst_rdata_clear: got %h expected 0", bus.S_R_DATA);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.S_W_READY !== 1'b1 || bus.S_W_COMPLETE !== 1'b0) begin
            errors++; $display("[TB] FAIL rst_release: got ready %b complete %b expected 1 0",
                               bus.S_W_READY, bus.S_W_COMPLETE);
        end
        do_read(64'h28, d, lat, e, va);
        checks++;
        if (d !== 64'hCAFEF00D12345678) begin
            errors++; $display("[TB] FAIL rst_mem_unchanged: got %h expected CAFEF00D12345678", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [63:0] d;
        int   lat;
        logic e, va;
        do_write(64'h78, 64'hA1B2C3D4E5F60718, 4'd3, lat, e);
        do_read(64'h7F, d, lat, e, va);
        checks++;
        if (d !== 64'h00000000000000A1) begin
            errors++; $display("[TB] FAIL last_byte: got %h expected 00000000000000A1", d);
        end
        do_read(64'h80, d, lat, e, va);
        checks++;
        if (d !== 64'h0 || lat !== 2) begin
            errors++; $display("[TB] FAIL oor_read: got %h lat %0d expected 0 lat 2", d, lat);
        end
`ifdef DMEM_RESPONDER_ERR_EN
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("[TB] FAIL oor_read_err: got %b expected 1", e);
        end
`endif
        do_write(64'h80, 64'hFFFFFFFFFFFFFFFF, 4'd3, lat, e);
        checks++;
        if (lat !== 2) begin
            errors++; $display("[TB] FAIL oor_write_complete: got lat %0d expected 2", lat);
        end
`ifdef DMEM_RESPONDER_ERR_EN
        checks++;
        if (e !== 1'b1) begin
            errors++; $display("[TB] FAIL oor_write_err: got %b expected 1", e);
        end
`endif
        do_read(64'h0, d, lat, e, va);
        checks++;
        if (d !== 64'h8877665544332211) begin
            errors++; $display("[TB] FAIL oor_no_alias: got %h expected 8877665544332211", d);
        end
    endtask

    initial begin
        $display("[TB] starting dmem_responder bench");
        test_reset();
        test_preload();
        test_read_aligned();
        test_half_write();
        test_cross_write();
        test_read_priority();
        test_reset_mid_write();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
